// File: rtl/pc_redirect_ctrl.sv
// Fetch-side PC generator with static not-taken prediction.
// EX-stage redirects reload the PC and flush IF/ID and ID/EX.
// A misaligned redirect target parks the block in HALT until reset.
// Saturating counters record resolved control-flow ops and taken redirects.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_redirect,
    input  logic             i_ctrl,
    input  logic [31:0]      i_target,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_pc_four,
    output logic             o_fetch_valid,
    output logic             o_flush_ifid,
    output logic             o_flush_idex,
    output logic             o_misalign,
    output logic [CNT_W-1:0] o_ctrl_cnt,
    output logic [CNT_W-1:0] o_redir_cnt
);

    localparam logic [0:0]       ST_RUN  = 1'b0;
    localparam logic [0:0]       ST_HALT = 1'b1;
    localparam logic [31:0]      PC_STEP = 32'd4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] ctrl_cnt_q, ctrl_cnt_d;
    logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
    logic             target_misaligned;

    assign target_misaligned = (i_target[1:0] != 2'b00);

    // State, PC and counter registers; reset discards any pending redirect.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            ctrl_cnt_q  <= '0;
            redir_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ctrl_cnt_q  <= ctrl_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    // Next-state, next-PC, counter update and flush/valid generation.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ctrl_cnt_d    = ctrl_cnt_q;
        redir_cnt_d   = redir_cnt_q;
        o_fetch_valid = 1'b0;
        o_flush_ifid  = 1'b0;
        o_flush_idex  = 1'b0;

        case (state_q)
            ST_RUN: begin
                o_fetch_valid = 1'b1;
                o_flush_ifid  = i_redirect;
                o_flush_idex  = i_redirect;

                // Redirect beats a same-cycle stall: the EX op is older.
                if (i_redirect && target_misaligned) begin
                    state_d = ST_HALT;
                end else if (i_redirect) begin
                    pc_d = {i_target[31:2], 2'b00};
                end else if (!i_stall) begin
                    pc_d = pc_q + PC_STEP;
                end

                if (i_ctrl && (ctrl_cnt_q != CNT_MAX)) begin
                    ctrl_cnt_d = ctrl_cnt_q + CNT_ONE;
                end
                if (i_redirect && (redir_cnt_q != CNT_MAX)) begin
                    redir_cnt_d = redir_cnt_q + CNT_ONE;
                end
            end
            ST_HALT: begin
                // Keep younger instructions from retiring while parked.
                o_flush_ifid = 1'b1;
                o_flush_idex = 1'b1;
            end
        endcase

        if (i_reset) begin
            o_fetch_valid = 1'b0;
            o_flush_ifid  = 1'b0;
            o_flush_idex  = 1'b0;
        end
    end

    assign o_pc        = pc_q;
    assign o_pc_four   = pc_q + PC_STEP;
    assign o_misalign  = (state_q == ST_HALT);
    assign o_ctrl_cnt  = ctrl_cnt_q;
    assign o_redir_cnt = redir_cnt_q;

`ifndef SYNTHESIS
    // A redirect must always come from a branch or jump in EX.
    always @(posedge i_clk) begin
        if (!i_reset) begin
            assert (!(i_redirect && !i_ctrl))
                else $error("pc_redirect_ctrl: redirect without control-flow op");
        end
    end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: a vector table for the main flow plus
// a hand-written sequence for counter saturation and reset-over-redirect.
module tb_pc_redirect_ctrl;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic        ctrl;
        logic [31:0] tgt;
        logic        exp_flush;
        logic        exp_fv;
        logic [31:0] exp_pc;
        logic        exp_mis;
        logic [15:0] exp_cc;
        logic [15:0] exp_rc;
    } vec_t;

    localparam int NVEC = 24;

    logic        clk = 1'b0;
    logic        i_reset, i_stall, i_redirect, i_ctrl;
    logic [31:0] i_target;

    logic [31:0] pc, pc_four;
    logic        fv, fl_ifid, fl_idex, mis;
    logic [15:0] cc, rc;

    logic [31:0] s_pc, s_pc_four;
    logic        s_fv, s_fl_ifid, s_fl_idex, s_mis;
    logic [1:0]  s_cc, s_rc;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    pc_redirect_ctrl dut (
        .i_clk(clk), .i_reset(i_reset), .i_stall(i_stall),
        .i_redirect(i_redirect), .i_ctrl(i_ctrl), .i_target(i_target),
        .o_pc(pc), .o_pc_four(pc_four), .o_fetch_valid(fv),
        .o_flush_ifid(fl_ifid), .o_flush_idex(fl_idex), .o_misalign(mis),
        .o_ctrl_cnt(cc), .o_redir_cnt(rc)
    );

    pc_redirect_ctrl #(.RESET_PC(32'h0000_1000), .CNT_W(2)) dut_s (
        .i_clk(clk), .i_reset(i_reset), .i_stall(i_stall),
        .i_redirect(i_redirect), .i_ctrl(i_ctrl), .i_target(i_target),
        .o_pc(s_pc), .o_pc_four(s_pc_four), .o_fetch_valid(s_fv),
        .o_flush_ifid(s_fl_ifid), .o_flush_idex(s_fl_idex), .o_misalign(s_mis),
        .o_ctrl_cnt(s_cc), .o_redir_cnt(s_rc)
    );

    function automatic vec_t mk(input logic rst, input logic stall, input logic redir,
                                input logic ctrl, input logic [31:0] tgt,
                                input logic flush, input logic fvalid,
                                input logic [31:0] epc, input logic emis,
                                input logic [15:0] ecc, input logic [15:0] erc);
        vec_t v;
        v.rst = rst; v.stall = stall; v.redir = redir; v.ctrl = ctrl; v.tgt = tgt;
        v.exp_flush = flush; v.exp_fv = fvalid; v.exp_pc = epc;
        v.exp_mis = emis; v.exp_cc = ecc; v.exp_rc = erc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic redir,
                         input logic ctrl, input logic [31:0] tgt);
        i_reset = rst; i_stall = stall; i_redirect = redir; i_ctrl = ctrl; i_target = tgt;
        #1;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst stall redir ctrl target | flush fv | pc after edge, misalign, ctrl_cnt, redir_cnt
        vecs[0]  = mk(1, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h4,         0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h8,         0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'hC,         0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h10,        0, 0, 0);
        vecs[6]  = mk(0, 1, 0, 0, 32'h0,         0, 1, 32'h10,        0, 0, 0);
        vecs[7]  = mk(0, 1, 0, 0, 32'h0,         0, 1, 32'h10,        0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h14,        0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h18,        0, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h1C,        0, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h20,        0, 0, 0);
        vecs[12] = mk(0, 0, 1, 1, 32'h100,       1, 1, 32'h100,       0, 1, 1);
        vecs[13] = mk(0, 0, 0, 1, 32'h0,         0, 1, 32'h104,       0, 2, 1);
        vecs[14] = mk(0, 1, 1, 1, 32'h40,        1, 1, 32'h40,        0, 3, 2);
        vecs[15] = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h44,        0, 3, 2);
        vecs[16] = mk(0, 0, 1, 1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 0, 4, 3);
        vecs[17] = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h0,         0, 4, 3);
        vecs[18] = mk(0, 0, 1, 1, 32'h30,        1, 1, 32'h30,        0, 5, 4);
        vecs[19] = mk(0, 0, 1, 1, 32'h102,       1, 1, 32'h30,        1, 6, 5);
        vecs[20] = mk(0, 0, 1, 1, 32'h200,       1, 0, 32'h30,        1, 6, 5);
        vecs[21] = mk(0, 1, 0, 0, 32'h0,         1, 0, 32'h30,        1, 6, 5);
        vecs[22] = mk(1, 0, 1, 1, 32'h80,        0, 0, 32'h0,         0, 0, 0);
        vecs[23] = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h4,         0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].ctrl, vecs[i].tgt);
            chk($sformatf("v%0d flush_ifid", i), 32'(fl_ifid), 32'(vecs[i].exp_flush));
            chk($sformatf("v%0d flush_idex", i), 32'(fl_idex), 32'(vecs[i].exp_flush));
            chk($sformatf("v%0d fetch_valid", i), 32'(fv), 32'(vecs[i].exp_fv));
            edge_settle();
            chk($sformatf("v%0d pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("v%0d pc_four", i), pc_four, vecs[i].exp_pc + 32'd4);
            chk($sformatf("v%0d misalign", i), 32'(mis), 32'(vecs[i].exp_mis));
            chk($sformatf("v%0d ctrl_cnt", i), 32'(cc), 32'(vecs[i].exp_cc));
            chk($sformatf("v%0d redir_cnt", i), 32'(rc), 32'(vecs[i].exp_rc));
        end

        // Narrow-counter instance: reset value and saturation at 3.
        drive(1, 0, 0, 0, 32'h0);
        edge_settle();
        chk("sat reset pc", s_pc, 32'h0000_1000);
        chk("sat reset cc", 32'(s_cc), 32'd0);
        for (int k = 0; k < 5; k++) begin
            logic [31:0] tgt;
            int          sat;
            tgt = 32'h100 + 32'(k) * 32'h8;
            sat = (k + 1 > 3) ? 3 : k + 1;
            drive(0, 0, 1, 1, tgt);
            chk($sformatf("sat%0d flush", k), 32'(s_fl_ifid), 32'd1);
            edge_settle();
            chk($sformatf("sat%0d s_pc", k), s_pc, tgt);
            chk($sformatf("sat%0d s_ctrl_cnt", k), 32'(s_cc), 32'(sat));
            chk($sformatf("sat%0d s_redir_cnt", k), 32'(s_rc), 32'(sat));
            chk($sformatf("sat%0d wide_redir_cnt", k), 32'(rc), 32'(k + 1));
        end

        // Reset during a RUN-state redirect: target dropped, flushes quiet.
        drive(1, 0, 1, 1, 32'h300);
        chk("rst_redir flush", 32'(fl_ifid), 32'd0);
        chk("rst_redir fv", 32'(fv), 32'd0);
        edge_settle();
        chk("rst_redir pc", pc, 32'h0);
        chk("rst_redir s_pc", s_pc, 32'h0000_1000);
        chk("rst_redir s_cc", 32'(s_cc), 32'd0);
        chk("rst_redir rc", 32'(rc), 32'd0);
        drive(0, 0, 0, 0, 32'h0);
        edge_settle();
        chk("post_rst pc", pc, 32'h4);
        chk("post_rst s_pc", s_pc, 32'h0000_1004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
